// File: rtl/uart_imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package uart_imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StCount,
    StData,
    StWrite,
    StCheck,
    StResp
  } loader_state_e;

  localparam logic [7:0] DefaultSyncByte = 8'hA5;
  localparam logic [7:0] DefaultAckByte  = 8'h06;
  localparam logic [7:0] DefaultNakByte  = 8'h15;

  // imem lives at byte address [31:28] == ImemRegion; also used by the memory-map decode.
  localparam logic [3:0] ImemRegion = 4'h1;

endpackage

// File: rtl/loader_word_asm.sv
// Packs little-endian data bytes into 32-bit words and keeps the running packet checksum.
module loader_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  input  logic        word_en,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [7:0]  sum
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;
  logic [7:0]  sum_q;

  // Every accepted byte feeds the checksum; only data-phase bytes shift into the word.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word_q <= '0;
      idx_q  <= '0;
      sum_q  <= '0;
    end else if (byte_valid) begin
      sum_q <= sum_q + byte_data;
      if (word_en) begin
        word_q <= {byte_data, word_q[31:8]};
        idx_q  <= idx_q + 2'd1;
      end
    end
  end

  // Flags the byte that completes a word; the word register holds it on the next cycle.
  always_comb begin
    word_valid = byte_valid && word_en && (idx_q == 2'd3);
  end

  assign word = word_q;
  assign sum  = sum_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Receives a framed program packet byte by byte, writes it into imem port a and answers ACK/NAK.
module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter int unsigned IMEM_AW        = 14,
  parameter logic [3:0]  IMEM_REGION    = ImemRegion,
  parameter logic [7:0]  SYNC_BYTE      = DefaultSyncByte,
  parameter logic [7:0]  ACK_BYTE       = DefaultAckByte,
  parameter logic [7:0]  NAK_BYTE       = DefaultNakByte,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               imem_en,
  output logic [3:0]         imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_din,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done
);

  localparam int unsigned ToW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

  loader_state_e      state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [IMEM_AW-1:0] word_idx_q, word_idx_d;
  logic               bad_q, bad_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic [ToW-1:0]     to_cnt_q, to_cnt_d;

  logic        accept, in_pkt, timeout, asm_clear, word_valid, write;
  logic [31:0] word;
  logic [7:0]  sum, sum_fin;

  assign accept  = rx_valid && rx_ready;
  assign in_pkt  = state_q inside {StAddr, StCount, StData, StCheck};
  // A byte arriving on the last idle cycle wins over the timeout.
  assign timeout = in_pkt && !accept && (to_cnt_q == ToLast);
  assign sum_fin = sum + rx_data;

  loader_word_asm u_word_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_data  (rx_data),
    .byte_valid (accept && in_pkt),
    .word_en    (state_q == StData),
    .clear      (asm_clear),
    .word       (word),
    .word_valid (word_valid),
    .sum        (sum)
  );

  // Packet framing FSM: next state, field capture and response selection.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    word_idx_d = word_idx_q;
    bad_d      = bad_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    cpu_hold_d = cpu_hold_q;
    asm_clear  = 1'b0;
    to_cnt_d   = in_pkt ? (accept ? '0 : to_cnt_q + ToW'(1)) : '0;

    case (state_q)
      StIdle: begin
        if (accept && (rx_data == SYNC_BYTE)) begin
          state_d    = StAddr;
          cpu_hold_d = 1'b1;
          idx_d      = '0;
          bad_d      = 1'b0;
          asm_clear  = 1'b1;
        end
      end
      StAddr: begin
        if (accept) begin
          addr_d = {rx_data, addr_q[31:8]};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = StCount;
            idx_d   = '0;
          end
        end
      end
      StCount: begin
        if (accept) begin
          cnt_d = {rx_data, cnt_q[15:8]};
          idx_d = idx_q + 2'd1;
          if (idx_q[0]) begin
            idx_d      = '0;
            word_idx_d = addr_q[IMEM_AW+1:2];
            if (cnt_d == 16'd0) begin
              state_d = StCheck;
            end else begin
              state_d = StData;
              bad_d   = (addr_q[1:0] != 2'b00) || (addr_q[31:28] != IMEM_REGION);
            end
          end
        end
      end
      StData: begin
        if (word_valid) state_d = StWrite;
      end
      StWrite: begin
        cnt_d      = cnt_q - 16'd1;
        word_idx_d = word_idx_q + IMEM_AW'(1);
        state_d    = (cnt_q == 16'd1) ? StCheck : StData;
      end
      StCheck: begin
        if (accept) begin
          state_d    = StResp;
          tx_valid_d = 1'b1;
          tx_data_d  = ((sum_fin == 8'h00) && !bad_q) ? ACK_BYTE : NAK_BYTE;
        end
      end
      StResp: begin
        if (tx_ready) begin
          state_d    = StIdle;
          tx_valid_d = 1'b0;
          cpu_hold_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (timeout) begin
      state_d    = StResp;
      tx_valid_d = 1'b1;
      tx_data_d  = NAK_BYTE;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      word_idx_q <= '0;
      bad_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      cpu_hold_q <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      word_idx_q <= word_idx_d;
      bad_q      <= bad_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      cpu_hold_q <= cpu_hold_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // Output decode; rst gates the write strobe so a write in the reset cycle is cancelled.
  always_comb begin
    write     = (state_q == StWrite) && !rst;
    rx_ready  = !(state_q inside {StWrite, StResp});
    busy      = (state_q != StIdle);
    done      = (state_q == StResp) && tx_ready && (tx_data_q == ACK_BYTE) && !rst;
    imem_en   = write;
    imem_we   = (write && !bad_q) ? 4'hF : 4'h0;
    imem_addr = write ? word_idx_q : '0;
    imem_din  = write ? word : '0;
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign cpu_hold = cpu_hold_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader: drives after posedge, samples on negedge.
module tb_uart_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        imem_en;
  logic [3:0]  imem_we;
  logic [13:0] imem_addr;
  logic [31:0] imem_din;
  logic        cpu_hold;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [13:0] wr_addr_q[$];
  logic [31:0] wr_din_q[$];
  logic [3:0]  wr_we_q[$];
  int          done_cnt = 0;
  bit          any_we   = 1'b0;
  logic [7:0]  pkt[$];

  always #5 clk = ~clk;

  uart_imem_loader #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .imem_en   (imem_en),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_din  (imem_din),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done)
  );

  // imem port-a and done monitor
  always @(negedge clk) begin
    if (imem_en) begin
      wr_addr_q.push_back(imem_addr);
      wr_din_q.push_back(imem_din);
      wr_we_q.push_back(imem_we);
    end
    if (imem_we != 4'h0) any_we = 1'b1;
    if (done) done_cnt++;
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_din_q.delete();
    wr_we_q.delete();
    done_cnt = 0;
    any_we   = 1'b0;
  endtask

  // Entered and left at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_byte: byte %h not accepted within 50 cycles, rx_ready=%b", b, rx_ready);
    end
  endtask

  task automatic send_pkt();
    foreach (pkt[i]) send_byte(pkt[i]);
  endtask

  // Checks response latency/value, completes the handshake and checks return to idle.
  task automatic finish_resp(input logic [7:0] exp, input string nm);
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s_latency: tx_valid=%b, expected 1", nm, tx_valid);
    end
    n_checks++;
    if (tx_data !== exp) begin
      n_fail++; $display("FAIL %s_tx_data: got %h, expected %h", nm, tx_data, exp);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({tx_valid, cpu_hold, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s_idle: {tx_valid,cpu_hold,busy}=%b, expected 000", nm,
               {tx_valid, cpu_hold, busy});
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string nm);
    n_checks++;
    if (rx_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_rx_ready: got %b, expected 1", nm, rx_ready);
    end
    n_checks++;
    if ({tx_valid, tx_data} !== 9'h000) begin
      n_fail++; $display("FAIL %s_tx: got valid=%b data=%h, expected 0/00", nm, tx_valid, tx_data);
    end
    n_checks++;
    if ({imem_en, imem_we, imem_addr, imem_din} !== 51'h0) begin
      n_fail++;
      $display("FAIL %s_imem: en=%b we=%h addr=%h din=%h, expected all 0", nm, imem_en, imem_we,
               imem_addr, imem_din);
    end
    n_checks++;
    if ({cpu_hold, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s_status: {cpu_hold,busy,done}=%b, expected 000", nm, {cpu_hold, busy, done});
    end
  endtask

  task automatic check_write(input int i, input logic [13:0] a, input logic [31:0] d,
                             input logic [3:0] we, input string nm);
    n_checks++;
    if ({wr_addr_q[i], wr_din_q[i], wr_we_q[i]} !== {a, d, we}) begin
      n_fail++;
      $display("FAIL %s_write%0d: got addr=%h din=%h we=%h, expected addr=%h din=%h we=%h", nm, i,
               wr_addr_q[i], wr_din_q[i], wr_we_q[i], a, d, we);
    end
  endtask

  task automatic check_count(input int got, input int exp, input string nm);
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ack();
    clear_log();
    pkt = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'h02, 8'h00,
            8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h13, 8'h00, 8'h00, 8'h00, 8'hA3};
    send_pkt();
    n_checks++;
    if (cpu_hold !== 1'b1) begin
      n_fail++; $display("FAIL ack_cpu_hold: got %b, expected 1", cpu_hold);
    end
    finish_resp(8'h06, "ack");
    check_count(wr_addr_q.size(), 2, "ack_write_count");
    if (wr_addr_q.size() == 2) begin
      check_write(0, 14'h0000, 32'hDEADBEEF, 4'hF, "ack");
      check_write(1, 14'h0001, 32'h00000013, 4'hF, "ack");
    end
    check_count(done_cnt, 1, "ack_done_pulses");
  endtask

  task automatic test_nak_csum();
    clear_log();
    pkt = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'h02, 8'h00,
            8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h13, 8'h00, 8'h00, 8'h00, 8'hA4};
    send_pkt();
    finish_resp(8'h15, "csum");
    check_count(wr_addr_q.size(), 2, "csum_write_count");
    if (wr_addr_q.size() == 2) check_write(1, 14'h0001, 32'h00000013, 4'hF, "csum");
    check_count(done_cnt, 0, "csum_done_pulses");
  endtask

  task automatic test_misaligned();
    clear_log();
    pkt = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h10, 8'h01, 8'h00,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h43};
    send_pkt();
    finish_resp(8'h15, "misalign");
    check_count(int'(any_we), 0, "misalign_any_we");
    check_count(done_cnt, 0, "misalign_done_pulses");
  endtask

  task automatic test_wrap();
    clear_log();
    pkt = '{8'hA5, 8'hFC, 8'hFF, 8'h00, 8'h10, 8'h02, 8'h00,
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hCF};
    send_pkt();
    finish_resp(8'h06, "wrap");
    check_count(wr_addr_q.size(), 2, "wrap_write_count");
    if (wr_addr_q.size() == 2) begin
      check_write(0, 14'h3FFF, 32'h04030201, 4'hF, "wrap");
      check_write(1, 14'h0000, 32'h08070605, 4'hF, "wrap");
    end
    check_count(done_cnt, 1, "wrap_done_pulses");
  endtask

  task automatic test_timeout();
    bit early = 1'b0;
    clear_log();
    pkt = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_pkt();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (tx_valid !== 1'b0) early = 1'b1;
    end
    n_checks++;
    if (early) begin
      n_fail++; $display("FAIL timeout_early: tx_valid rose before 16 idle cycles, expected 0");
    end
    @(negedge clk);
    n_checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h15}) begin
      n_fail++;
      $display("FAIL timeout_nak: got valid=%b data=%h, expected 1/15", tx_valid, tx_data);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, cpu_hold} !== 2'b00) begin
      n_fail++; $display("FAIL timeout_idle: {busy,cpu_hold}=%b, expected 00", {busy, cpu_hold});
    end
    @(posedge clk); #1;

    // Last address byte lands on the final idle cycle: it must win over the timeout.
    pkt = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_pkt();
    repeat (15) begin
      @(posedge clk); #1;
    end
    send_byte(8'h10);
    @(negedge clk);
    n_checks++;
    if ({tx_valid, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_edge_byte: {tx_valid,busy}=%b, expected 01", {tx_valid, busy});
    end
    @(posedge clk); #1;
    pkt = '{8'h00, 8'h00, 8'hF0};
    send_pkt();
    finish_resp(8'h06, "timeout_edge");
  endtask

  task automatic test_resp_hold();
    bit unstable = 1'b0;
    clear_log();
    pkt = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'hF0};
    send_pkt();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ({tx_valid, tx_data, rx_ready} !== {1'b1, 8'h06, 1'b0}) unstable = 1'b1;
    end
    n_checks++;
    if (unstable) begin
      n_fail++;
      $display("FAIL hold_stable: valid=%b data=%h rx_ready=%b, expected 1/06/0 throughout",
               tx_valid, tx_data, rx_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("hold_reset");
    check_count(done_cnt, 0, "hold_done_pulses");
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_ack();
    test_nak_csum();
    test_misaligned();
    test_wrap();
    test_timeout();
    test_resp_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
